// File: rtl/range_window_stage.sv
// Window-bound stage: lo=r1, hi=r1+r2 clipped to the index range.
// Results pass through a 2-entry FIFO; clipped accepts are counted.
module range_window_stage #(
  parameter int W1    = 8,
  parameter int W2    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W1-1:0]    r1,
  input  logic [W2-1:0]    r2,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W1-1:0]    lo,
  output logic [W1-1:0]    hi,
  output logic [W1-1:0]    span,
  output logic             sat,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10,
    BAD   = 2'b11
  } st_t;

  typedef struct packed {
    logic [W1-1:0] lo;
    logic [W1-1:0] hi;
    logic [W1-1:0] span;
    logic          sat;
  } rec_t;

  st_t          st_q, st_d;
  rec_t         head_q, tail_q, nw;
  logic [W1:0]  sum;
  logic         push, pop;

  assign in_ready  = (st_q == EMPTY) || (st_q == ONE);
  assign out_valid = (st_q == ONE) || (st_q == FULL);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign state     = st_q;

  // Sum carries one extra bit so overflow past the index range is visible.
  always_comb begin
    nw      = '0;
    sum     = {1'b0, r1} + (W1+1)'(r2);
    nw.lo   = r1;
    nw.sat  = sum[W1];
    nw.hi   = sum[W1] ? {W1{1'b1}} : sum[W1-1:0];
    nw.span = nw.hi - r1;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      EMPTY: if (push) st_d = ONE;
      ONE: begin
        if (push && !pop)      st_d = FULL;
        else if (pop && !push) st_d = EMPTY;
      end
      FULL:    if (pop) st_d = ONE;
      default: st_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= EMPTY;
    else     st_q <= st_d;
  end

  // Head is entry 0; a push at occupancy 1 with a pop goes straight to head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (st_q)
        EMPTY: if (push) head_q <= nw;
        ONE: begin
          if (push && pop) head_q <= nw;
          else if (push)   tail_q <= nw;
        end
        FULL:    if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      viol_cnt <= '0;
    else if (clr)
      viol_cnt <= '0;
    else if (push && nw.sat && viol_cnt != {CNT_W{1'b1}})
      viol_cnt <= viol_cnt + CNT_W'(1);
  end

  assign lo   = out_valid ? head_q.lo   : '0;
  assign hi   = out_valid ? head_q.hi   : '0;
  assign span = out_valid ? head_q.span : '0;
  assign sat  = out_valid ? head_q.sat  : 1'b0;

endmodule

// File: tb/tb_range_window_stage.sv
// Directed bench for range_window_stage with W1=8, W2=4, CNT_W=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_range_window_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r1;
  logic [3:0] r2;
  logic       clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] lo, hi, span;
  logic       sat;
  logic [7:0] viol_cnt;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  range_window_stage #(.W1(8), .W2(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .lo(lo), .hi(hi), .span(span), .sat(sat),
    .viol_cnt(viol_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    r1 = '0;
    r2 = '0;
    clr = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst state", state, 0);
    chk("rst viol", viol_cnt, 0);
    chk("rst lo", lo, 0);
    chk("rst hi", hi, 0);
    chk("rst span", span, 0);
    chk("rst sat", sat, 0);
    tick();
    rst = 1'b0;

    // plain window
    in_valid = 1'b1; r1 = 8'd10; r2 = 4'd5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("a out_valid", out_valid, 1);
    chk("a lo", lo, 10);
    chk("a hi", hi, 15);
    chk("a span", span, 5);
    chk("a sat", sat, 0);
    chk("a state", state, 1);
    tick();
    chk("a popped state", state, 0);
    chk("a popped valid", out_valid, 0);
    chk("a popped lo", lo, 0);

    // clipped window
    in_valid = 1'b1; r1 = 8'd250; r2 = 4'd15;
    tick();
    in_valid = 1'b0;
    chk("b hi", hi, 255);
    chk("b span", span, 5);
    chk("b sat", sat, 1);
    chk("b viol", viol_cnt, 1);
    tick();
    chk("b popped state", state, 0);

    // fill with downstream stalled
    out_ready = 1'b0;
    in_valid = 1'b1; r1 = 8'd1; r2 = 4'd1;
    tick();
    chk("c1 state", state, 1);
    chk("c1 in_ready", in_ready, 1);
    r1 = 8'd2; r2 = 4'd2;
    tick();
    chk("c2 state", state, 2);
    chk("c2 in_ready", in_ready, 0);
    r1 = 8'd3; r2 = 4'd3;
    tick();
    chk("c3 held state", state, 2);
    chk("c3 held lo", lo, 1);
    chk("c3 held hi", hi, 2);
    chk("c viol unchanged", viol_cnt, 1);
    out_ready = 1'b1;
    tick();
    chk("c pop2 lo", lo, 2);
    chk("c pop2 hi", hi, 4);
    chk("c pop2 state", state, 1);
    tick();
    in_valid = 1'b0;
    chk("c pop3 lo", lo, 3);
    chk("c pop3 hi", hi, 6);
    chk("c pop3 state", state, 1);
    tick();
    chk("c drained state", state, 0);

    // counter saturation: 256 clipping accepts on top of 1
    in_valid = 1'b1; r1 = 8'd255; r2 = 4'd1;
    for (int i = 0; i < 256; i++) tick();
    chk("d viol sat", viol_cnt, 255);
    chk("d sat out", sat, 1);
    chk("d hi", hi, 255);
    chk("d span", span, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("d clr viol", viol_cnt, 0);
    tick();
    chk("d drained state", state, 0);

    // async reset while full
    out_ready = 1'b0;
    in_valid = 1'b1; r1 = 8'd1; r2 = 4'd1;
    tick();
    r1 = 8'd2; r2 = 4'd2;
    tick();
    in_valid = 1'b0;
    chk("e full state", state, 2);
    #3;
    rst = 1'b1;
    #1;
    chk("e rst out_valid", out_valid, 0);
    chk("e rst state", state, 0);
    chk("e rst in_ready", in_ready, 1);
    chk("e rst lo", lo, 0);
    #2;
    rst = 1'b0;
    in_valid = 1'b1; r1 = 8'd4; r2 = 4'd4; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("e lo", lo, 4);
    chk("e hi", hi, 8);
    chk("e span", span, 4);
    chk("e out_valid", out_valid, 1);
    chk("e state", state, 1);
    tick();
    chk("e drained state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
